// File: rtl/rr_encoder_16to4_pkg.sv
// rtl/rr_encoder_16to4_pkg.sv - shared types for the round-robin 16-to-4 encoder
package enc_pkg;

  localparam int N_REQ_DEF = 16;
  localparam int IDX_W_DEF = 4;

  typedef logic [N_REQ_DEF-1:0] req_vec_t;
  typedef logic [IDX_W_DEF-1:0] req_idx_t;

  typedef enum logic {IDLE, HOLD} enc_state_t;

endpackage

// File: rtl/rr_encoder_16to4_prio_enc.sv
// rtl/rr_encoder_16to4_prio_enc.sv - combinational lowest-index-first 16-to-4 priority encoder
module prio_enc_16to4
  import enc_pkg::*;
(
  input  req_vec_t vec,
  output req_idx_t idx,
  output logic     found
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_REQ_DEF - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = req_idx_t'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_encoder_16to4.sv
// rtl/rr_encoder_16to4.sv - round-robin 16-to-4 encoder with valid/ready output and one-hot grant
// Optional: RR_ENC_FIXED_PRIO_EN selects lowest-index-first instead of round-robin.
module rr_encoder_16to4
  import enc_pkg::*;
#(
  parameter  int N_REQ = 16,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] gnt
);

  enc_state_t       state;
  logic             hs;
  logic [N_REQ-1:0] eff;
  logic             any_req;
  logic [IDX_W-1:0] pick;
  req_vec_t         eff16;
  req_idx_t         unm_idx;
  logic             unm_found;

  assign out_valid = (state == HOLD);
  assign hs        = out_valid & out_ready;

  always_comb begin
    gnt      = '0;
    gnt[idx] = hs;
  end

  // The just-accepted source is excluded from the same-edge reselection.
  assign eff     = req & ~gnt;
  assign any_req = |eff;

  always_comb begin
    eff16           = '0;
    eff16[N_REQ-1:0] = eff;
  end

  prio_enc_16to4 u_unmasked (
    .vec   (eff16),
    .idx   (unm_idx),
    .found (unm_found)
  );

`ifdef RR_ENC_FIXED_PRIO_EN

  assign pick = unm_idx[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= HOLD;
            idx   <= pick;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (any_req) idx <= pick;
            else         state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] base;
  logic [N_REQ-1:0] mask;
  req_vec_t         msk16;
  req_idx_t         msk_idx;
  logic             msk_found;

  // On a handshake the search restarts just past the index being accepted.
  assign base = hs ? idx : ptr;

  always_comb begin
    mask  = '0;
    msk16 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (i > int'(base));
    end
    msk16[N_REQ-1:0] = eff & mask;
  end

  prio_enc_16to4 u_masked (
    .vec   (msk16),
    .idx   (msk_idx),
    .found (msk_found)
  );

  assign pick = msk_found ? msk_idx[IDX_W-1:0] : unm_idx[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      ptr   <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= HOLD;
            idx   <= pick;
          end
        end
        HOLD: begin
          if (out_ready) begin
            ptr <= idx;
            if (any_req) idx <= pick;
            else         state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_rr_encoder_16to4.sv
// tb/tb_rr_encoder_16to4.sv - directed self-checking bench for rr_encoder_16to4
module tb_rr_encoder_16to4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  idx;
  logic [15:0] gnt;

  int n_checks = 0;
  int n_fail   = 0;

  rr_encoder_16to4 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .idx       (idx),
    .gnt       (gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    req       = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] i, input logic [15:0] g);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) check({tag, ".idx"}, 32'(idx), 32'(i));
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
  endtask

  logic [3:0] seq_8421 [5];
  logic [3:0] seq_fix  [4];

  initial begin
    seq_8421 = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0};
    seq_fix  = '{4'd1, 4'd2, 4'd1, 4'd2};

    // Reset state and idle with no requests, out_ready ignored
    do_reset();
    expect_out("reset", 1'b0, 4'd0, 16'h0000);
    check("reset.idx", 32'(idx), 32'd0);
    set_in(16'h0000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_out($sformatf("idle%0d", c), 1'b0, 4'd0, 16'h0000);
    end

    // Single persistent requester served every other cycle
    do_reset();
    set_in(16'h0001, 1'b1);
    tick();
    expect_out("single.c1", 1'b1, 4'd0, 16'h0001);
    tick();
    expect_out("single.c2", 1'b0, 4'd0, 16'h0000);
    tick();
    expect_out("single.c3", 1'b1, 4'd0, 16'h0001);

    // Async reset mid-HOLD drops output before the next edge
    rst = 1'b1;
    #1;
    expect_out("async_rst", 1'b0, 4'd0, 16'h0000);
    rst = 1'b0;
    set_in(16'h0000, 1'b0);
    tick();
    expect_out("after_rst", 1'b0, 4'd0, 16'h0000);

    // HOLD stability with out_ready low, then handshake
    do_reset();
    set_in(16'h0300, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("hold%0d", c), 1'b1, 4'd8, 16'h0000);
    end
    set_in(16'h0200, 1'b0);
    tick();
    expect_out("hold_drop", 1'b1, 4'd8, 16'h0000);
    set_in(16'h0200, 1'b1);
    expect_out("hold_hs", 1'b1, 4'd8, 16'h0100);
    tick();
    expect_out("hold_next", 1'b1, 4'd9, 16'h0200);

`ifdef RR_ENC_FIXED_PRIO_EN
    do_reset();
    set_in(16'h0006, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("fix6_%0d", c), 1'b1, seq_fix[c], 16'(16'h1 << seq_fix[c]));
    end
    do_reset();
    set_in(16'h000E, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("fixE_%0d", c), 1'b1, seq_fix[c], 16'(16'h1 << seq_fix[c]));
    end
`else
    // Back-to-back round-robin over 0,5,10,15 and wrap
    do_reset();
    set_in(16'h8421, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_out($sformatf("rr%0d", c), 1'b1, seq_8421[c], 16'(16'h1 << seq_8421[c]));
    end

    // Wrap past 15 after accepting 14
    do_reset();
    set_in(16'h4000, 1'b1);
    tick();
    expect_out("wrap.a", 1'b1, 4'd14, 16'h4000);
    set_in(16'h4001, 1'b1);
    tick();
    expect_out("wrap.b", 1'b1, 4'd0, 16'h0001);

    // Lone requester at ptr is masked on handshake edge, reselected after
    do_reset();
    set_in(16'h4000, 1'b1);
    tick();
    expect_out("self.a", 1'b1, 4'd14, 16'h4000);
    tick();
    expect_out("self.b", 1'b0, 4'd0, 16'h0000);
    tick();
    expect_out("self.c", 1'b1, 4'd14, 16'h4000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_encoder_16to4.md
Name: rr_encoder_16to4

Overview:
- Sequential round-robin 16-to-4 encoder: the inverse of the register-file write-select decoder.
- Takes up to 16 level requests, for example writeback sources contending for the register-file write port.
- Selects one request per transaction in round-robin order and presents its 4-bit index on a valid/ready output.
- Returns a one-hot grant pulse to the winner at handshake; the downstream decoder re-expands the index into write enables.

Parameters:
- N_REQ, 16, number of request lines; power of 2, 2..16.
- IDX_W, $clog2(N_REQ), index width; derived, must not be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req  input  N_REQ  level requests; bit i asserted = source i wants service.
- out_ready  input  1  consumer accepts idx this cycle.
- out_valid  output  1  idx holds a selected request.
- idx  output  IDX_W  binary index of selected request.
- gnt  output  N_REQ  one-hot grant pulse, combinational = decode(idx) & {N_REQ{out_valid & out_ready}}.

Behaviour:
- Reset, asynchronous: out_valid=0, idx=0, ptr=N_REQ-1, so the first search starts at index 0. gnt=0 follows.
- State: IDLE (out_valid=0) and HOLD (out_valid=1). ptr is an internal register holding the last accepted index.
- Search order: the first set bit of the effective request vector starting at ptr+1 mod N_REQ, ascending, wrapping to 0.
- Implementation of the search: masked priority pick (bits above ptr); if nothing is found there, unmasked pick.
- IDLE, with req nonzero at edge N: the register loads idx=pick and out_valid=1, visible after edge N. Latency 1 cycle.
- IDLE, with req=0: stay in IDLE.
- HOLD with out_ready=0: idx and out_valid stay stable.
  - Deassertion of req[idx] does not retract the output.
  - New requests do not change idx.
- HOLD with out_ready=1 (handshake):
  - gnt pulses one-hot for that cycle.
  - ptr<=idx.
  - Same edge: the next selection uses effective vector req & ~gnt, with search starting at idx+1.
  - If that vector is nonzero: stay in HOLD with the new idx, giving back-to-back throughput of 1 per cycle. Otherwise go to IDLE.
- Accepted index masking: the just-accepted index is never re-selected on the handshake edge, even if its req is still high. It is eligible again from the next cycle.
- Single persistent requester: it is served every other cycle.
- out_ready while out_valid=0: ignored, gnt=0.
- Wrap: with ptr=N_REQ-1, the search starts at 0. With ptr=k and only req[k] set, req[k] is selected, except on the handshake edge.
- Reset mid-HOLD: output dropped immediately, no gnt, pending transaction lost.

Optional Feature:
- RR_ENC_FIXED_PRIO_EN defined:
  - ptr is removed.
  - Selection is always the lowest-index set bit of the effective vector.
  - The accepted-index mask on the handshake edge still applies.
- Undefined: round-robin as above.

Decomposition:
- Package enc_pkg:
  - localparam N_REQ_DEF=16 and IDX_W_DEF=4.
  - typedef logic [N_REQ_DEF-1:0] req_vec_t.
  - typedef logic [IDX_W_DEF-1:0] req_idx_t.
  - typedef enum logic {IDLE, HOLD} enc_state_t.
- Sub-module prio_enc_16to4: combinational lowest-index-first priority encoder.
  - Input vec[15:0]; outputs idx[3:0] and found.
  - Instantiated twice, for the masked and unmasked vectors.

Test Plan:
- Reset then req=16'h0000 for 5 cycles -> out_valid=0, gnt=0. Assert rst async mid-cycle in HOLD -> out_valid falls before the next edge.
- req=16'h0001 at cycle 0, out_ready=1 -> idx=0 valid at cycle 1, gnt=16'h0001 at cycle 1, out_valid=0 at cycle 2, re-selected at cycle 3 (every other cycle).
- req=16'h8421 held, out_ready=1 -> idx sequence 0,5,10,15,0 on consecutive cycles, one gnt per cycle.
- req=16'h0300, out_ready=0 for 4 cycles, then req drops to 16'h0200 -> idx stays 8. Raise out_ready -> gnt=16'h0100, next idx=9.
- ptr=14 (after accepting 14), req=16'h4001 -> next idx=0 (wrap). With req=16'h4000 only -> idx=14 selected one cycle after the handshake.
- RR_ENC_FIXED_PRIO_EN defined, req=16'h0006 held, out_ready=1 -> idx 1,2,1,2 (masking alternates). req=16'h000E -> idx 1,2,1,2 (3 starves).
